// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operand/result sequencer: default widths and
// the sequencer state encoding.
package alu_op_sequencer_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int RES_W_DEF  = 16;
    localparam int MODE_W     = 3;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_ISSUE = 2'd1,
        SEQ_WAIT  = 2'd2,
        SEQ_RESP  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/alu_op_sequencer_saturate.sv
// Converts a signed Q8.8 ALU result to a saturated Q4.4 value. The block is
// purely combinational so any ALU result consumer can reuse it.
module alu_res_saturate
    import alu_op_sequencer_pkg::*;
#(
    parameter int RES_W     = RES_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int FRAC_BITS = 4
) (
    input  logic [RES_W-1:0]  res_i,
    output logic [DATA_W-1:0] sat_o,
    output logic              ovf_o
);

    localparam int MAX_I = (1 << (DATA_W - 1)) - 1;
    localparam int MIN_I = -(1 << (DATA_W - 1));
    localparam logic signed [RES_W-1:0] SAT_MAX = RES_W'(MAX_I);
    localparam logic signed [RES_W-1:0] SAT_MIN = RES_W'(MIN_I);

    logic signed [RES_W-1:0] shifted;

    assign shifted = $signed(res_i) >>> FRAC_BITS;

    always_comb begin
        sat_o = shifted[DATA_W-1:0];
        ovf_o = 1'b0;
        if (shifted > SAT_MAX) begin
            sat_o = SAT_MAX[DATA_W-1:0];
            ovf_o = 1'b1;
        end else if (shifted < SAT_MIN) begin
            sat_o = SAT_MIN[DATA_W-1:0];
            ovf_o = 1'b1;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Initiator for the fixed-point ALU: accepts one command, issues it as a
// one-cycle strobe, waits for the result with a timeout and returns it.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int RES_W     = RES_W_DEF,
    parameter int FRAC_BITS = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [DATA_W-1:0] cmd_op1_i,
    input  logic [DATA_W-1:0] cmd_op2_i,
    input  logic [MODE_W-1:0] cmd_mode_i,
    output logic [DATA_W-1:0] alu_op1_o,
    output logic [DATA_W-1:0] alu_op2_o,
    output logic [MODE_W-1:0] alu_mode_o,
    output logic              alu_valid_o,
    input  logic [RES_W-1:0]  alu_res_i,
    input  logic              alu_valid_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [RES_W-1:0]  rsp_res_o,
    output logic [DATA_W-1:0] rsp_sat_o,
    output logic              rsp_ovf_o,
    output logic              rsp_timeout_o,
    output logic              stray_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic              alu_valid_q, alu_valid_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [RES_W-1:0]  res_q, res_d;
    logic [DATA_W-1:0] sat_q, sat_d;
    logic              ovf_q, ovf_d;
    logic              timeout_q, timeout_d;
    logic              stray_q, stray_d;
    logic [DATA_W-1:0] sat_w;
    logic              ovf_w;

    alu_res_saturate #(
        .RES_W    (RES_W),
        .DATA_W   (DATA_W),
        .FRAC_BITS(FRAC_BITS)
    ) u_sat (
        .res_i(alu_res_i),
        .sat_o(sat_w),
        .ovf_o(ovf_w)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        mode_d    = mode_q;
        res_d     = res_q;
        sat_d     = sat_q;
        ovf_d     = ovf_q;
        timeout_d = timeout_q;
        stray_d   = stray_q | (alu_valid_i &&
                               (state_q == SEQ_IDLE || state_q == SEQ_RESP));

        case (state_q)
            SEQ_IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    op1_d   = cmd_op1_i;
                    op2_d   = cmd_op2_i;
                    mode_d  = cmd_mode_i;
                    state_d = SEQ_ISSUE;
                end
            end
            SEQ_ISSUE: begin
                cnt_d = '0;
                if (alu_valid_i) begin
                    res_d     = alu_res_i;
                    sat_d     = sat_w;
                    ovf_d     = ovf_w;
                    timeout_d = 1'b0;
                    state_d   = SEQ_RESP;
                end else begin
                    state_d = SEQ_WAIT;
                end
            end
            SEQ_WAIT: begin
                if (alu_valid_i) begin
                    res_d     = alu_res_i;
                    sat_d     = sat_w;
                    ovf_d     = ovf_w;
                    timeout_d = 1'b0;
                    state_d   = SEQ_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    res_d     = '0;
                    sat_d     = '0;
                    ovf_d     = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = SEQ_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SEQ_RESP: begin
                if (rsp_ready_i) begin
                    state_d = SEQ_IDLE;
                end
            end
            default: state_d = SEQ_IDLE;
        endcase

        // Handshake flags follow the state being entered so they are registered.
        cmd_ready_d = (state_d == SEQ_IDLE);
        alu_valid_d = (state_d == SEQ_ISSUE);
        rsp_valid_d = (state_d == SEQ_RESP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SEQ_IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            mode_q      <= '0;
            alu_valid_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            res_q       <= '0;
            sat_q       <= '0;
            ovf_q       <= 1'b0;
            timeout_q   <= 1'b0;
            stray_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            mode_q      <= mode_d;
            alu_valid_q <= alu_valid_d;
            rsp_valid_q <= rsp_valid_d;
            res_q       <= res_d;
            sat_q       <= sat_d;
            ovf_q       <= ovf_d;
            timeout_q   <= timeout_d;
            stray_q     <= stray_d;
        end
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign alu_op1_o     = op1_q;
    assign alu_op2_o     = op2_q;
    assign alu_mode_o    = mode_q;
    assign alu_valid_o   = alu_valid_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_res_o     = res_q;
    assign rsp_sat_o     = sat_q;
    assign rsp_ovf_o     = ovf_q;
    assign rsp_timeout_o = timeout_q;
    assign stray_o       = stray_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed scoreboard bench for alu_op_sequencer.
module tb_alu_op_sequencer;

    localparam int TIMEOUT = 16;

    typedef struct {
        logic [15:0] res;
        logic [7:0]  sat;
        logic        ovf;
        logic        to;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [7:0]  cmd_op1_i, cmd_op2_i;
    logic [2:0]  cmd_mode_i;
    logic [7:0]  alu_op1_o, alu_op2_o;
    logic [2:0]  alu_mode_o;
    logic        alu_valid_o;
    logic [15:0] alu_res_i;
    logic        alu_valid_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [15:0] rsp_res_o;
    logic [7:0]  rsp_sat_o;
    logic        rsp_ovf_o;
    logic        rsp_timeout_o;
    logic        stray_o;

    int   compared   = 0;
    int   mismatched = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_op_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_op1_i    (cmd_op1_i),
        .cmd_op2_i    (cmd_op2_i),
        .cmd_mode_i   (cmd_mode_i),
        .alu_op1_o    (alu_op1_o),
        .alu_op2_o    (alu_op2_o),
        .alu_mode_o   (alu_mode_o),
        .alu_valid_o  (alu_valid_o),
        .alu_res_i    (alu_res_i),
        .alu_valid_i  (alu_valid_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_res_o    (rsp_res_o),
        .rsp_sat_o    (rsp_sat_o),
        .rsp_ovf_o    (rsp_ovf_o),
        .rsp_timeout_o(rsp_timeout_o),
        .stray_o      (stray_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] r);
        exp_t e;
        int   s;
        s     = int'($signed(r)) >>> 4;
        e.res = r;
        e.to  = 1'b0;
        if (s > 127) begin
            e.sat = 8'h7F;
            e.ovf = 1'b1;
        end else if (s < -128) begin
            e.sat = 8'h80;
            e.ovf = 1'b1;
        end else begin
            e.sat = s[7:0];
            e.ovf = 1'b0;
        end
        return e;
    endfunction

    // Accept one command, then play the ALU: answer lat cycles after the issue
    // cycle (or never) and measure how many edges it takes to see rsp_valid_o.
    task automatic run_op(input logic [7:0] op1, input logic [7:0] op2,
                          input logic [2:0] mode, input int lat,
                          input logic answer, input logic [15:0] res);
        int   w;
        int   n;
        exp_t e;
        cmd_valid_i = 1'b1;
        cmd_op1_i   = op1;
        cmd_op2_i   = op2;
        cmd_mode_i  = mode;
        w = 0;
        while (!cmd_ready_o && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check("cmd_ready_before_accept", cmd_ready_o, 1);
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        if (answer) e = model(res);
        else begin
            e.res = '0; e.sat = '0; e.ovf = 1'b0; e.to = 1'b1;
        end
        sb.push_back(e);
        check("issue_strobe", alu_valid_o, 1);
        check("issue_ops", {alu_op1_o, alu_op2_o, alu_mode_o}, {op1, op2, mode});
        check("cmd_ready_after_accept", cmd_ready_o, 0);
        n = 0;
        while (!rsp_valid_o && n < 100) begin
            alu_valid_i = answer && (n == lat);
            alu_res_i   = res;
            @(posedge clk); #1;
            alu_valid_i = 1'b0;
            n++;
            if (n == 1) check("strobe_one_cycle", alu_valid_o, 0);
        end
        check("rsp_latency", n, answer ? lat + 1 : TIMEOUT + 1);
    endtask

    // Hold rsp_ready_i low for hold cycles, optionally with the next command
    // already asserted, then compare against the scoreboard and handshake.
    task automatic collect(input int hold, input logic next_pending,
                           input logic [7:0] nop1, input logic [7:0] nop2,
                           input logic [2:0] nmode);
        exp_t        e;
        logic [15:0] res0;
        logic [7:0]  op1_0;
        res0  = rsp_res_o;
        op1_0 = alu_op1_o;
        if (next_pending) begin
            cmd_valid_i = 1'b1;
            cmd_op1_i   = nop1;
            cmd_op2_i   = nop2;
            cmd_mode_i  = nmode;
        end
        rsp_ready_i = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("bp_rsp_valid", rsp_valid_o, 1);
            check("bp_rsp_stable", rsp_res_o, res0);
            check("bp_cmd_ready", cmd_ready_o, 0);
            check("bp_ops_held", {alu_op1_o, alu_valid_o}, {op1_0, 1'b0});
        end
        if (sb.size() == 0) begin
            check("scoreboard_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            check("rsp_res", rsp_res_o, e.res);
            check("rsp_sat", rsp_sat_o, e.sat);
            check("rsp_ovf", rsp_ovf_o, e.ovf);
            check("rsp_timeout", rsp_timeout_o, e.to);
        end
        rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        rsp_ready_i = 1'b0;
        check("post_hs_rsp_valid", rsp_valid_o, 0);
        check("post_hs_cmd_ready", cmd_ready_o, 1);
        check("post_hs_not_accepted", alu_valid_o, 0);
        check("post_hs_hold", rsp_res_o, res0);
    endtask

    initial begin
        rst         = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_op1_i   = '0;
        cmd_op2_i   = '0;
        cmd_mode_i  = '0;
        alu_res_i   = '0;
        alu_valid_i = 1'b0;
        rsp_ready_i = 1'b0;

        #3;
        check("reset_alu_side", {cmd_ready_o, alu_op1_o, alu_op2_o, alu_mode_o, alu_valid_o}, 0);
        check("reset_rsp_side", {rsp_valid_o, rsp_res_o, rsp_sat_o, rsp_ovf_o, rsp_timeout_o, stray_o}, 0);
        #19 rst = 1'b1;
        #1;
        check("ready_low_before_edge", cmd_ready_o, 0);
        @(posedge clk); #1;
        check("ready_first_edge", cmd_ready_o, 1);

        run_op(8'd16, 8'd2, 3'd5, 2, 1'b1, 16'h0020);
        collect(0, 1'b0, 8'h0, 8'h0, 3'd0);
        run_op(8'h40, 8'h40, 3'd1, 1, 1'b1, 16'h7F00);
        collect(0, 1'b0, 8'h0, 8'h0, 3'd0);
        run_op(8'h80, 8'h70, 3'd2, 3, 1'b1, 16'h8000);
        collect(0, 1'b0, 8'h0, 8'h0, 3'd0);
        run_op(8'h7F, 8'h10, 3'd3, 0, 1'b1, 16'h07F0);
        collect(0, 1'b0, 8'h0, 8'h0, 3'd0);
        run_op(8'hFD, 8'h05, 3'd4, 1, 1'b1, 16'hFFF0);
        collect(5, 1'b1, 8'h10, 8'h10, 3'd6);
        run_op(8'h10, 8'h10, 3'd6, 0, 1'b1, 16'h0100);
        collect(0, 1'b0, 8'h0, 8'h0, 3'd0);

        check("stray_clear_before_timeout", stray_o, 0);
        run_op(8'h01, 8'h02, 3'd7, 0, 1'b0, 16'h0000);
        collect(0, 1'b0, 8'h0, 8'h0, 3'd0);
        alu_valid_i = 1'b1;
        alu_res_i   = 16'h1234;
        @(posedge clk); #1;
        alu_valid_i = 1'b0;
        check("late_answer_stray", stray_o, 1);
        check("late_answer_no_rsp", rsp_valid_o, 0);

        cmd_valid_i = 1'b1;
        cmd_op1_i   = 8'h11;
        cmd_op2_i   = 8'h22;
        cmd_mode_i  = 3'd3;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        check("mid_wait_issue", alu_valid_o, 1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #1;
        check("mid_reset_alu_side", {cmd_ready_o, alu_op1_o, alu_op2_o, alu_mode_o, alu_valid_o}, 0);
        check("mid_reset_rsp_side", {rsp_valid_o, rsp_res_o, rsp_sat_o, rsp_ovf_o, rsp_timeout_o, stray_o}, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("release_ready", cmd_ready_o, 1);
        check("release_stray_clear", stray_o, 0);
        alu_valid_i = 1'b1;
        alu_res_i   = 16'h0100;
        @(posedge clk); #1;
        alu_valid_i = 1'b0;
        check("inflight_stray", stray_o, 1);
        for (int i = 0; i < 4; i++) begin
            check("inflight_no_rsp", rsp_valid_o, 0);
            @(posedge clk); #1;
        end
        check("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
